// File: rtl/hvrx_pkg.sv
// Shared definitions for the hvrx TMDS receive decoder: control tokens, alignment
// FSM states and token classification.
package hvrx_pkg;

  localparam logic [9:0] CTL_TOK_00 = 10'b1101010100;
  localparam logic [9:0] CTL_TOK_01 = 10'b0010101011;
  localparam logic [9:0] CTL_TOK_10 = 10'b0101010100;
  localparam logic [9:0] CTL_TOK_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    WAIT   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  typedef struct packed {
    logic       is_tok;
    logic [1:0] ctl;
  } tok_info_t;

  function automatic tok_info_t tok_ctl(input logic [9:0] sym);
    tok_info_t r;
    r.is_tok = 1'b1;
    r.ctl    = 2'b00;
    case (sym)
      CTL_TOK_00: r.ctl = 2'b00;
      CTL_TOK_01: r.ctl = 2'b01;
      CTL_TOK_10: r.ctl = 2'b10;
      CTL_TOK_11: r.ctl = 2'b11;
      default:    r.is_tok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/hvrx_tmds_dec.sv
// Combinational TMDS 10b symbol decode: control-token classification plus the
// 8-bit data recovery (conditional inversion, then XOR/XNOR chain undo).
module hvrx_tmds_dec
  import hvrx_pkg::*;
(
  input  logic [9:0] sym,
  output logic       is_tok,
  output logic [1:0] ctl,
  output logic [7:0] data
);

  tok_info_t  info;
  logic [7:0] d;

  always_comb begin
    info    = tok_ctl(sym);
    d       = sym[9] ? ~sym[7:0] : sym[7:0];
    data    = 8'd0;
    data[0] = d[0];
    // sym[8] selects whether the encoder chained with XOR or XNOR
    for (int i = 1; i < 8; i++) begin
      data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  assign is_tok = info.is_tok;
  assign ctl    = info.ctl;

endmodule

// File: rtl/hvrx_dec.sv
// Single-channel TMDS receive decoder with blanking-run word alignment.
// Optional lock-loss counter on o_err_cnt is enabled by defining HVRX_ERR_CNT_EN.
module hvrx_dec
  import hvrx_pkg::*;
#(
  parameter int LOCK_TOKENS   = 16,
  parameter int SEARCH_WINDOW = 4096,
  parameter int SLIP_WAIT     = 8
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic [9:0]  i_sym,
  output logic        o_bitslip,
  output logic        o_locked,
  output logic        o_de,
  output logic [1:0]  o_ctl,
  output logic [7:0]  o_data,
  output logic [15:0] o_err_cnt,
  output logic [1:0]  o_state
);

  localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int WIN_W  = $clog2(SEARCH_WINDOW) + 1;
  localparam int WAIT_W = $clog2(SLIP_WAIT) + 1;

  localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(LOCK_TOKENS);
  localparam logic [RUN_W-1:0]  RUN_HIT   = RUN_W'(LOCK_TOKENS - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  state_t             state, state_nx;
  logic [RUN_W-1:0]   run_cnt, run_nx;
  logic [WIN_W-1:0]   win_cnt, win_nx;
  logic [WAIT_W-1:0]  wait_cnt, wait_nx;

  logic               sym_tok;
  logic [1:0]         sym_ctl;
  logic [7:0]         sym_data;
  logic               counting;
  logic               qual;

  hvrx_tmds_dec u_tmds_dec (
    .sym    (i_sym),
    .is_tok (sym_tok),
    .ctl    (sym_ctl),
    .data   (sym_data)
  );

  // Tokens only count toward a run while the deserializer alignment is stable.
  assign counting = (state == SEARCH) || (state == LOCKED);
  assign qual     = counting && sym_tok && (run_cnt == RUN_HIT);

  always_comb begin
    state_nx = state;
    run_nx   = run_cnt;
    win_nx   = win_cnt;
    wait_nx  = wait_cnt;
    case (state)
      SEARCH, LOCKED: begin
        if (!sym_tok) begin
          run_nx = '0;
        end else if (run_cnt != RUN_MAX) begin
          run_nx = run_cnt + RUN_W'(1);
        end
        // A run completing on the expiry cycle wins over the slip.
        if (qual) begin
          state_nx = LOCKED;
          win_nx   = '0;
        end else if (win_cnt == WIN_LAST) begin
          state_nx = SLIP;
          win_nx   = '0;
        end else begin
          win_nx = win_cnt + WIN_W'(1);
        end
      end
      SLIP: begin
        state_nx = WAIT;
        run_nx   = '0;
        wait_nx  = '0;
      end
      WAIT: begin
        run_nx = '0;
        if (wait_cnt == WAIT_LAST) begin
          state_nx = SEARCH;
          wait_nx  = '0;
          win_nx   = '0;
        end else begin
          wait_nx = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        state_nx = SEARCH;
        run_nx   = '0;
        win_nx   = '0;
        wait_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      state    <= SEARCH;
      run_cnt  <= '0;
      win_cnt  <= '0;
      wait_cnt <= '0;
      o_de     <= 1'b0;
      o_ctl    <= 2'b00;
      o_data   <= 8'd0;
    end else begin
      state    <= state_nx;
      run_cnt  <= run_nx;
      win_cnt  <= win_nx;
      wait_cnt <= wait_nx;
      if (sym_tok) begin
        o_de   <= 1'b0;
        o_ctl  <= sym_ctl;
        o_data <= 8'd0;
      end else begin
        o_de   <= 1'b1;
        o_data <= sym_data;
      end
    end
  end

  // Bitslip comes straight from the registered state, so reset removes it at once.
  assign o_bitslip = (state == SLIP);
  assign o_locked  = (state == LOCKED);
  assign o_state   = state;

`ifdef HVRX_ERR_CNT_EN
  logic        lock_loss;
  logic [15:0] err_cnt;

  assign lock_loss = (state == LOCKED) && (state_nx == SLIP);

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      err_cnt <= 16'd0;
    end else if (lock_loss && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hvrx_dec.sv
// Directed bench for hvrx_dec: lock, data decode, lock loss, simultaneous
// expiry/lock, reset during WAIT and bitslip realignment of a rotated stream.
module tb_hvrx_dec;
  import hvrx_pkg::*;

  localparam int LOCK_TOKENS   = 16;
  localparam int SEARCH_WINDOW = 64;
  localparam int SLIP_WAIT     = 8;

  localparam logic [9:0] VEC_SYM [8] = '{
    10'h100, 10'h300, CTL_TOK_11, 10'h0FF, 10'h0B6, CTL_TOK_01, 10'h3C3, CTL_TOK_10
  };
  // {de, ctl[1:0], data[7:0]}
  localparam logic [10:0] VEC_EXP [8] = '{
    {1'b1, 2'd0, 8'h00}, {1'b1, 2'd0, 8'h01}, {1'b0, 2'd3, 8'h00}, {1'b1, 2'd3, 8'hFF},
    {1'b1, 2'd3, 8'h24}, {1'b0, 2'd1, 8'h00}, {1'b1, 2'd1, 8'h44}, {1'b0, 2'd2, 8'h00}
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  sym = 10'd0;
  logic        o_bitslip;
  logic        o_locked;
  logic        o_de;
  logic [1:0]  o_ctl;
  logic [7:0]  o_data;
  logic [15:0] o_err_cnt;
  logic [1:0]  o_state;

  int test_cnt   = 0;
  int fail_cnt   = 0;
  int slip_seen  = 0;
  logic [10:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  hvrx_dec #(
    .LOCK_TOKENS   (LOCK_TOKENS),
    .SEARCH_WINDOW (SEARCH_WINDOW),
    .SLIP_WAIT     (SLIP_WAIT)
  ) dut (
    .i_pclk    (clk),
    .i_rst     (rst),
    .i_sym     (sym),
    .o_bitslip (o_bitslip),
    .o_locked  (o_locked),
    .o_de      (o_de),
    .o_ctl     (o_ctl),
    .o_data    (o_data),
    .o_err_cnt (o_err_cnt),
    .o_state   (o_state)
  );

  // driver: apply a symbol for one cycle and sample 1 time unit after the edge
  task automatic tick(input logic [9:0] s);
    sym = s;
    @(posedge clk);
    #1;
    if (o_bitslip) slip_seen++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rot_sym(input logic [9:0] s, input int k);
    logic [19:0] dbl;
    dbl = {s, s};
    return dbl[k +: 10];
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_de"},   32'(o_de),      32'd0);
    check({tag, "_ctl"},  32'(o_ctl),     32'd0);
    check({tag, "_data"}, 32'(o_data),    32'd0);
    check({tag, "_slip"}, 32'(o_bitslip), 32'd0);
    check({tag, "_lock"}, 32'(o_locked),  32'd0);
    check({tag, "_err"},  32'(o_err_cnt), 32'd0);
    check({tag, "_st"},   32'(o_state),   32'(SEARCH));
  endtask

  initial begin
    int rot_k;
    int lock_at;
    int pulse_at[$];
    logic [10:0] exp;

    // reset with data on the input: everything must stay at 0
    rst = 1'b1;
    tick(10'h0B6);
    tick(10'h0B6);
    check_idle("reset");
    rst = 1'b0;

    // 16 blanking tokens lock on the 16th
    for (int i = 0; i < 15; i++) tick(CTL_TOK_00);
    check("lock_15", 32'(o_locked), 32'd0);
    tick(CTL_TOK_00);
    check("lock_16", 32'(o_locked), 32'd1);
    check("lock_de", 32'(o_de), 32'd0);
    check("lock_ctl", 32'(o_ctl), 32'd0);
    check("lock_noslip", 32'(slip_seen), 32'd0);

    // decode vectors through the expected queue
    for (int v = 0; v < 8; v++) begin
      exp_q.push_back(VEC_EXP[v]);
      tick(VEC_SYM[v]);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'h7FF;
      check($sformatf("dec_%0d", v), 32'({o_de, o_ctl, o_data}), 32'(exp));
    end

    // fresh run, then data only for a full window -> lock loss
    tick(10'h100);
    for (int i = 0; i < 16; i++) tick(CTL_TOK_00);
    check("relock_a", 32'(o_locked), 32'd1);
    for (int i = 0; i < SEARCH_WINDOW - 1; i++) tick(10'h100);
    check("loss_pre_slip", 32'(o_bitslip), 32'd0);
    check("loss_pre_lock", 32'(o_locked), 32'd1);
    tick(10'h100);
    check("loss_slip", 32'(o_bitslip), 32'd1);
    check("loss_lock", 32'(o_locked), 32'd0);
    check("loss_state", 32'(o_state), 32'(SLIP));
`ifdef HVRX_ERR_CNT_EN
    check("loss_err", 32'(o_err_cnt), 32'd1);
`else
    check("loss_err", 32'(o_err_cnt), 32'd0);
`endif
    tick(10'h100);
    check("wait_slip", 32'(o_bitslip), 32'd0);
    check("wait_state", 32'(o_state), 32'(WAIT));

    // reset in the middle of WAIT
    tick(CTL_TOK_00);
    tick(CTL_TOK_00);
    rst = 1'b1;
    tick(CTL_TOK_11);
    check_idle("rst_wait");
    rst = 1'b0;
    for (int i = 0; i < 15; i++) tick(CTL_TOK_00);
    check("relock_15", 32'(o_locked), 32'd0);
    tick(CTL_TOK_00);
    check("relock_16", 32'(o_locked), 32'd1);

    // 16th token lands exactly on the window-expiry cycle
    for (int i = 0; i < SEARCH_WINDOW - LOCK_TOKENS; i++) tick(10'h300);
    for (int i = 0; i < LOCK_TOKENS - 1; i++) tick(CTL_TOK_00);
    check("edge_pre_slip", 32'(o_bitslip), 32'd0);
    tick(CTL_TOK_00);
    check("edge_lock", 32'(o_locked), 32'd1);
    check("edge_slip", 32'(o_bitslip), 32'd0);
    for (int i = 0; i < 10; i++) tick(10'h300);
    check("edge_no_pulse", 32'(slip_seen), 32'd1);
    check("edge_state", 32'(o_state), 32'(LOCKED));

    // token stream rotated by 3 bits; each pulse moves it one bit closer
    rst = 1'b1;
    tick(CTL_TOK_00);
    rst = 1'b0;
    rot_k   = 3;
    lock_at = -1;
    for (int c = 1; c <= 280; c++) begin
      tick(rot_sym(CTL_TOK_00, rot_k));
      if (o_bitslip) begin
        pulse_at.push_back(c);
        if (rot_k > 0) rot_k--;
      end
      if (o_locked && (lock_at < 0)) lock_at = c;
    end
    check("rot_pulses", 32'(pulse_at.size()), 32'd3);
    check("rot_p0", 32'((pulse_at.size() > 0) ? pulse_at[0] : -1), 32'd64);
    check("rot_p1", 32'((pulse_at.size() > 1) ? pulse_at[1] : -1), 32'd137);
    check("rot_p2", 32'((pulse_at.size() > 2) ? pulse_at[2] : -1), 32'd210);
    check("rot_lock_at", 32'(lock_at), 32'd235);
    check("rot_locked", 32'(o_locked), 32'd1);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
